// File: rtl/serial_tx_stage.sv
// serial_tx_stage
// Output stage behind the 8-bit rotate/load register. It takes a parallel word
// through a load/ready handshake and sends it on one line as an asynchronous
// serial frame: start bit, 8 data bits LSB first, optional even parity, then
// one or two stop bits. Every output comes straight from a flop, so the pin
// driven by tx cannot glitch.

module serial_tx_stage #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       load,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int                 DIV_W     = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0]   DIV_ZERO  = DIV_W'(0);
    localparam logic [2:0]         STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Even parity: XOR of all bits, so ones(word) + parity is always even.
    function automatic logic even_parity(input logic [7:0] word);
        return ^word;
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q, par_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end_s;

    // State and output registers; reset abandons any frame and parks the line at mark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= 8'h00;
            par_q    <= 1'b0;
            bitcnt_q <= 3'd0;
            div_q    <= DIV_ZERO;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            bitcnt_q <= bitcnt_d;
            div_q    <= div_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: bit sequencing, divider, data shifting and word capture.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        bitcnt_d  = bitcnt_q;
        div_d     = div_q;
        bit_end_s = (div_q == DIV_LAST);
        case (state_q)
            S_IDLE: begin
                div_d    = DIV_ZERO;
                bitcnt_d = 3'd0;
                if (load && ready_q) begin
                    shreg_d = data;
                    par_d   = even_parity(data);
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    div_d    = DIV_ZERO;
                    bitcnt_d = 3'd0;
                    state_d  = S_DATA;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    div_d   = DIV_ZERO;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        bitcnt_d = 3'd0;
                        state_d  = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    div_d    = DIV_ZERO;
                    bitcnt_d = 3'd0;
                    state_d  = S_STOP;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            S_STOP: begin
                // bitcnt is reused here to count stop bits.
                if (bit_end_s) begin
                    div_d = DIV_ZERO;
                    if (bitcnt_q == STOP_LAST) begin
                        bitcnt_d = 3'd0;
                        state_d  = S_IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                div_d    = DIV_ZERO;
                bitcnt_d = 3'd0;
            end
        endcase
    end

    // Output logic: derived from the next state so tx changes on the edge that enters a bit.
    always_comb begin
        tx_d    = 1'b1;
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_STOP) && bit_end_s && (bitcnt_q == STOP_LAST);
        case (state_d)
            S_IDLE:   tx_d = 1'b1;
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = par_d;
            S_STOP:   tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx    = tx_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_tx_stage.sv
// Bench for serial_tx_stage: three instances cover the default configuration,
// the no-parity configuration and the two-stop-bit / fast-clock configuration.
module tb_serial_tx_stage;

    logic       clk;
    logic       rst;
    logic [7:0] data_a [3];
    logic [2:0] load_v;
    logic [2:0] tx_v, ready_v, busy_v, done_v;

    int total;
    int bad;

    // observed {tx, busy, ready, done} per cycle after the accepting edge
    logic [3:0] trace [0:255];

    serial_tx_stage #(.CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .data(data_a[0]), .load(load_v[0]),
        .ready(ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    serial_tx_stage #(.CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .data(data_a[1]), .load(load_v[1]),
        .ready(ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    serial_tx_stage #(.CLKS_PER_BIT(2), .PARITY_EN(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .data(data_a[2]), .load(load_v[2]),
        .ready(ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb(input int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic int pen(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    function automatic int nstop(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int i);
        return (9 + pen(i) + nstop(i)) * cpb(i);
    endfunction

    // Reference: expected {tx,busy,ready,done} k cycles after the accepting edge.
    function automatic logic [3:0] expected_obs(input int i, input logic [7:0] w, input int k);
        int   slot;
        int   ones;
        logic b;
        if (k > frame_len(i)) return 4'b1011;
        ones = 0;
        for (int n = 0; n < 8; n++) ones += int'(w[n]);
        slot = (k - 1) / cpb(i);
        if (slot == 0)                         b = 1'b0;
        else if (slot <= 8)                    b = w[slot-1];
        else if (pen(i) != 0 && slot == 9)     b = ((ones % 2) == 1);
        else                                   b = 1'b1;
        return {b, 3'b100};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs ncyc cycles recording outputs. Mid-frame, load/data are junk (or held
    // load with next_data when keep_load); in the last cycle next_load/next_data
    // are applied so a following frame may start back-to-back.
    task automatic capture(input int i, input int ncyc, input bit keep_load,
                           input logic next_load, input logic [7:0] next_data);
        for (int k = 1; k <= ncyc; k++) begin
            step();
            trace[k] = {tx_v[i], busy_v[i], ready_v[i], done_v[i]};
            if (k < ncyc) begin
                load_v[i] = keep_load ? 1'b1 : 1'($urandom % 2);
                data_a[i] = keep_load ? next_data : 8'($urandom);
            end else begin
                load_v[i] = next_load;
                data_a[i] = next_data;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({tx_v[i], busy_v[i], ready_v[i], done_v[i]} !== 4'b1010) begin
                bad++;
                $display("FAIL reset_state inst=%0d got=%b exp=1010", i,
                         {tx_v[i], busy_v[i], ready_v[i], done_v[i]});
            end
        end
        for (int c = 0; c < 20; c++) begin
            step();
            total++;
            if (tx_v !== 3'b111 || ready_v !== 3'b111) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d tx=%b ready=%b exp tx=111 ready=111", c, tx_v, ready_v);
            end
        end
    endtask

    task automatic test_single_frame();
        int busy_cnt;
        int done_at;
        int n;
        n = frame_len(0) + 1;
        data_a[0] = 8'hA5;
        load_v[0] = 1'b1;
        capture(0, n, 1'b0, 1'b0, 8'h00);
        busy_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= n; k++) begin
            total++;
            if (trace[k] !== expected_obs(0, 8'hA5, k)) begin
                bad++;
                $display("FAIL a5_frame cyc=%0d got=%b exp=%b", k, trace[k], expected_obs(0, 8'hA5, k));
            end
            if (trace[k][2]) busy_cnt++;
            if (trace[k][0] && done_at == 0) done_at = k;
        end
        total++;
        if (busy_cnt !== 44) begin
            bad++;
            $display("FAIL a5_busy_cycles got=%0d exp=44", busy_cnt);
        end
        total++;
        if (done_at !== 45) begin
            bad++;
            $display("FAIL a5_done_cycle got=%0d exp=45", done_at);
        end
        step();
        total++;
        if ({tx_v[0], busy_v[0], ready_v[0], done_v[0]} !== 4'b1010) begin
            bad++;
            $display("FAIL a5_done_single got=%b exp=1010", {tx_v[0], busy_v[0], ready_v[0], done_v[0]});
        end
    endtask

    task automatic test_parity();
        int busy_cnt;
        int done_at;
        // parity enabled: 8'h07 has three ones, so the parity bit is 1
        data_a[0] = 8'h07;
        load_v[0] = 1'b1;
        capture(0, frame_len(0) + 1, 1'b0, 1'b0, 8'h00);
        for (int k = 1; k <= frame_len(0) + 1; k++) begin
            total++;
            if (trace[k] !== expected_obs(0, 8'h07, k)) begin
                bad++;
                $display("FAIL par07_frame cyc=%0d got=%b exp=%b", k, trace[k], expected_obs(0, 8'h07, k));
            end
        end
        total++;
        if (trace[37][3] !== 1'b1) begin
            bad++;
            $display("FAIL par07_bit got=%b exp=1", trace[37][3]);
        end
        step();
        // parity disabled: 40-cycle frame, no parity slot
        data_a[1] = 8'h07;
        load_v[1] = 1'b1;
        capture(1, frame_len(1) + 1, 1'b0, 1'b0, 8'h00);
        busy_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= frame_len(1) + 1; k++) begin
            total++;
            if (trace[k] !== expected_obs(1, 8'h07, k)) begin
                bad++;
                $display("FAIL nopar_frame cyc=%0d got=%b exp=%b", k, trace[k], expected_obs(1, 8'h07, k));
            end
            if (trace[k][2]) busy_cnt++;
            if (trace[k][0] && done_at == 0) done_at = k;
        end
        total++;
        if (busy_cnt !== 40 || done_at !== 41) begin
            bad++;
            $display("FAIL nopar_length busy=%0d done_at=%0d exp busy=40 done_at=41", busy_cnt, done_at);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        n = frame_len(0) + 1;
        data_a[0] = 8'h01;
        load_v[0] = 1'b1;
        capture(0, n, 1'b1, 1'b1, 8'hFF);
        for (int k = 1; k <= n; k++) begin
            total++;
            if (trace[k] !== expected_obs(0, 8'h01, k)) begin
                bad++;
                $display("FAIL b2b_first cyc=%0d got=%b exp=%b", k, trace[k], expected_obs(0, 8'h01, k));
            end
        end
        capture(0, n, 1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= n; k++) begin
            total++;
            if (trace[k] !== expected_obs(0, 8'hFF, k)) begin
                bad++;
                $display("FAIL b2b_second cyc=%0d got=%b exp=%b", k, trace[k], expected_obs(0, 8'hFF, k));
            end
        end
        step();
        total++;
        if ({tx_v[0], busy_v[0], ready_v[0], done_v[0]} !== 4'b1010) begin
            bad++;
            $display("FAIL b2b_idle got=%b exp=1010", {tx_v[0], busy_v[0], ready_v[0], done_v[0]});
        end
    endtask

    task automatic test_reset_mid_frame();
        data_a[0] = 8'h3C;
        load_v[0] = 1'b1;
        step();
        load_v[0] = 1'b0;
        repeat (17) step();
        // now inside data bit 3; assert reset between edges
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({tx_v[0], busy_v[0], ready_v[0], done_v[0]} !== 4'b1010) begin
            bad++;
            $display("FAIL rstmid_async got=%b exp=1010", {tx_v[0], busy_v[0], ready_v[0], done_v[0]});
        end
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            total++;
            if ({tx_v[0], busy_v[0], ready_v[0], done_v[0]} !== 4'b1010) begin
                bad++;
                $display("FAIL rstmid_after cyc=%0d got=%b exp=1010", c, {tx_v[0], busy_v[0], ready_v[0], done_v[0]});
            end
        end
        data_a[0] = 8'h3C;
        load_v[0] = 1'b1;
        capture(0, frame_len(0) + 1, 1'b0, 1'b0, 8'h00);
        for (int k = 1; k <= frame_len(0) + 1; k++) begin
            total++;
            if (trace[k] !== expected_obs(0, 8'h3C, k)) begin
                bad++;
                $display("FAIL rstmid_reload cyc=%0d got=%b exp=%b", k, trace[k], expected_obs(0, 8'h3C, k));
            end
        end
        step();
    endtask

    task automatic test_two_stop();
        int busy_cnt;
        int done_at;
        data_a[2] = 8'h80;
        load_v[2] = 1'b1;
        capture(2, frame_len(2) + 1, 1'b0, 1'b0, 8'h00);
        busy_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= frame_len(2) + 1; k++) begin
            total++;
            if (trace[k] !== expected_obs(2, 8'h80, k)) begin
                bad++;
                $display("FAIL stop2_frame cyc=%0d got=%b exp=%b", k, trace[k], expected_obs(2, 8'h80, k));
            end
            if (trace[k][2]) busy_cnt++;
            if (trace[k][0] && done_at == 0) done_at = k;
        end
        total++;
        if (busy_cnt !== 24 || done_at !== 25) begin
            bad++;
            $display("FAIL stop2_length busy=%0d done_at=%0d exp busy=24 done_at=25", busy_cnt, done_at);
        end
        total++;
        if ({trace[21][3], trace[22][3], trace[23][3], trace[24][3]} !== 4'b1111) begin
            bad++;
            $display("FAIL stop2_high got=%b exp=1111",
                     {trace[21][3], trace[22][3], trace[23][3], trace[24][3]});
        end
        step();
    endtask

    task automatic test_random_frames();
        int         i;
        int         gap;
        logic [7:0] w;
        for (int f = 0; f < 12; f++) begin
            i   = int'($urandom_range(0, 2));
            w   = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            data_a[i] = w;
            load_v[i] = 1'b1;
            capture(i, frame_len(i) + 1, 1'b0, 1'b0, 8'h00);
            for (int k = 1; k <= frame_len(i) + 1; k++) begin
                total++;
                if (trace[k] !== expected_obs(i, w, k)) begin
                    bad++;
                    $display("FAIL rand_frame f=%0d inst=%0d w=%h cyc=%0d got=%b exp=%b",
                             f, i, w, k, trace[k], expected_obs(i, w, k));
                end
            end
            for (int c = 0; c < gap; c++) begin
                step();
                total++;
                if ({tx_v[i], busy_v[i], ready_v[i], done_v[i]} !== 4'b1010) begin
                    bad++;
                    $display("FAIL rand_gap f=%0d inst=%0d got=%b exp=1010",
                             f, i, {tx_v[i], busy_v[i], ready_v[i], done_v[i]});
                end
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        load_v = 3'b000;
        for (int i = 0; i < 3; i++) data_a[i] = 8'h00;
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_two_stop();
        test_random_frames();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
